uart8_receiver: RTL and testbench
=================================

// Module: uart8_receiver
// PURPOSE
//  Downstream partner of the UART transmitter: recovers 8N1 frames (1 start, 8 data LSB-first,
//  1 stop) from the serial line the transmitter drives. Runs on an oversampling clock
//  (OVERSAMPLE x baud) and presents each received byte with a one-cycle done strobe.
//  The port names mirror the transmitter's, so loopback benches can wire tx.out -> rx.in directly.
// PARAMETERS
//  OVERSAMPLE  16  clk cycles per bit period; even, >= 4; mid-bit sample at tick OVERSAMPLE/2-1
// PORTS
//  clk   in   1  oversampling clock (OVERSAMPLE x baud)
//  rst   in   1  asynchronous, active-high reset
//  en    in   1  enable; 0 freezes FSM and counters
//  in    in   1  serial line, idle high, asynchronous to clk
//  out   out  8  last received byte; held until the next frame completes
//  done  out  1  one-cycle pulse: frame complete, out/err valid
//  busy  out  1  high while a frame is in progress (state != IDLE)
//  err   out  1  framing error (stop bit sampled 0); updated with each done
// BEHAVIOUR
//  Reset: state=IDLE, out=8'h00, done=0, busy=0, err=0, sync flops=2'b11, armed=0, counters=0.
//  Input: 2-flop synchronizer on in -> rxs; the synchronizer runs regardless of en.
//  tick: 0..OVERSAMPLE-1 counter, cleared on every state change.
//  bitidx: 0..7 counter.
//  FSM (advances only when en=1; the state is also registered and unchanged when en=0):
//   IDLE:      armed<=1 when rxs=1. If armed && rxs=0 -> START_BIT, tick=0.
//   START_BIT: at tick=OVERSAMPLE/2-1, rxs=1 -> false start -> IDLE (no done, armed stays 1).
//              At tick=OVERSAMPLE-1 -> DATA_BITS, bitidx=0.
//   DATA_BITS: at tick=OVERSAMPLE/2-1, shift <= {rxs, shift[7:1]}.
//              At tick=OVERSAMPLE-1: if bitidx=7 -> STOP_BIT, else bitidx++.
//   STOP_BIT:  at tick=OVERSAMPLE/2-1: out<=shift, err<=~rxs, done<=1 on the next edge (registered),
//              -> IDLE. armed<=rxs, so a line held low (break) cannot retrigger a frame
//              until it returns high.
//  Leaving STOP_BIT at mid-bit leaves half a bit for resync; back-to-back frames with one
//  stop bit are received.
//  done: registered and high for exactly one cycle; forced 0 on any cycle with en=0.
//  busy: registered; goes high the cycle after START_BIT is entered and low the cycle
//   after IDLE is re-entered.
//  Latency: done rises 3 cycles after the mid-stop sample point on the line
//   (2 synchronizer cycles + 1 output register).
//  en=0 mid-frame: tick, bitidx and state hold; on resume, counting continues from the
//   held values. No data is discarded; line timing is the bench's responsibility.
//  rst mid-frame: immediate abort to the reset values; no done; the partial byte is lost;
//   out returns to 0.
//  err is sticky only until the next done, which rewrites it.
//  Only 8N1 is supported: no parity, no fixed-up stop bits.
// TESTING (rx clk = 16x tx clk, tx from the UART transmitter, en=1 unless stated)
//  1. Send 0x55 -> one done pulse, out=8'h55, err=0; busy high from start detect through the
//     stop bit, then 0.
//  2. Send 0x55 then 0x96 back-to-back, 1 stop bit each -> two done pulses, out=8'h55
//     then 8'h96, err=0 both.
//  3. Drive in low for 4 rx clks, then high -> busy pulses briefly, returns to 0 by
//     tick 8; no done.
//  4. Frame 0xA5 with stop bit forced 0, line then held low 40 bit-times -> done, out=8'hA5,
//     err=1; no further done until the line returns high and a valid 0x3C frame arrives
//     (out=8'h3C, err=0).
//  5. Assert rst during data bit 3 of 0xF0 -> out=0, busy=0, no done; next frame 0x0F
//     -> out=8'h0F, err=0.
//  6. Drop en for 20 rx clks at start-of-frame before the line falls, with tx idle ->
//     no state change; after en=1, frame 0x81 -> out=8'h81, done asserted once.

Source files
------------

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver running on an oversampling clock; mid-bit sampling,
// one-cycle done strobe, framing error flag and break (line-low) lockout.
//
// state     | meaning
// IDLE      | waiting for a falling edge on an armed (previously high) line
// START_BIT | validating the start bit at mid-bit, then timing out its period
// DATA_BITS | sampling 8 data bits LSB-first at mid-bit
// STOP_BIT  | sampling the stop bit at mid-bit, publishing the byte
module uart8_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       done,
  output logic       busy,
  output logic       err
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rxs;
  logic [TW-1:0] tick;
  logic [2:0]    bitidx;
  logic [7:0]    shift;
  logic          armed;
  logic          at_mid, at_last;

  assign rxs     = sync[1];
  assign at_mid  = (tick == T_MID);
  assign at_last = (tick == T_LAST);

  // two-flop synchronizer, free-running so the line is tracked even while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], in};
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; disabled cycles hold the current state
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:      if (armed && !rxs) state_nxt = START_BIT;
        START_BIT: if (at_mid && rxs) state_nxt = IDLE;
                   else if (at_last)  state_nxt = DATA_BITS;
        DATA_BITS: if (at_last && bitidx == 3'd7) state_nxt = STOP_BIT;
        STOP_BIT:  if (at_mid) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // bit timing, data shift, arming and byte/error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick   <= '0;
      bitidx <= 3'd0;
      shift  <= 8'h00;
      armed  <= 1'b0;
      out    <= 8'h00;
      err    <= 1'b0;
    end else if (en) begin
      if (state_nxt != state)   tick <= '0;
      else if (state != IDLE)   tick <= at_last ? '0 : tick + 1'b1;

      if (state == START_BIT && state_nxt == DATA_BITS)
        bitidx <= 3'd0;
      else if (state == DATA_BITS && at_last && bitidx != 3'd7)
        bitidx <= bitidx + 3'd1;

      if (state == DATA_BITS && at_mid)
        shift <= {rxs, shift[7:1]};

      // a stop bit sampled low leaves the receiver disarmed until the line recovers
      if (state == IDLE && rxs)
        armed <= 1'b1;
      else if (state == STOP_BIT && at_mid)
        armed <= rxs;

      if (state == STOP_BIT && at_mid) begin
        out <= shift;
        err <= ~rxs;
      end
    end
  end

  // registered status: one-cycle done strobe (never while disabled) and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= en && (state == STOP_BIT) && at_mid;
      busy <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed bench for uart8_receiver: frames are driven bit-by-bit at 16 rx clocks per bit.
module tb_uart8_receiver;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       line = 1'b1;
  logic [7:0] dout;
  logic       done, busy, err;

  int n_cmp = 0;
  int n_err = 0;

  int done_cnt  = 0;
  int busy_cyc  = 0;
  logic [7:0] rx_q[$];
  logic       err_q[$];

  uart8_receiver #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (line),
    .out (dout),
    .done(done),
    .busy(busy),
    .err (err)
  );

  always #5 clk = ~clk;

  // count done cycles and busy cycles, log byte/error at each done
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      rx_q.push_back(dout);
      err_q.push_back(err);
    end
    if (busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
    drive_bit(stop, OS);
  endtask

  int d0, b0, q0;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_out",  {24'd0, dout}, 32'h00);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_err",  {31'd0, err},  32'h0);
    rst = 1'b0;
    drive_bit(1'b1, 20);

    // 1: single 0x55
    d0 = done_cnt; b0 = busy_cyc; q0 = rx_q.size();
    send_byte(8'h55, 1'b1);
    drive_bit(1'b1, 6);
    chk("t1_cnt",  done_cnt - d0, 1);
    chk("t1_out",  {24'd0, dout}, 32'h55);
    chk("t1_err",  {31'd0, err}, 32'h0);
    chk("t1_busyseen", (busy_cyc - b0 > 150) ? 1 : 0, 1);
    chk("t1_busy_end", {31'd0, busy}, 32'h0);

    // 2: back-to-back 0x55, 0x96
    d0 = done_cnt; q0 = rx_q.size();
    send_byte(8'h55, 1'b1);
    send_byte(8'h96, 1'b1);
    drive_bit(1'b1, 8);
    chk("t2_cnt", done_cnt - d0, 2);
    if (rx_q.size() >= q0 + 2) begin
      chk("t2_b0",  {24'd0, rx_q[q0]},   32'h55);
      chk("t2_b1",  {24'd0, rx_q[q0+1]}, 32'h96);
      chk("t2_e0",  {31'd0, err_q[q0]},   32'h0);
      chk("t2_e1",  {31'd0, err_q[q0+1]}, 32'h0);
    end

    // 3: 4-cycle glitch low is rejected as a false start
    d0 = done_cnt; b0 = busy_cyc;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 24);
    chk("t3_cnt", done_cnt - d0, 0);
    chk("t3_busyseen", (busy_cyc - b0 > 0) ? 1 : 0, 1);
    chk("t3_busyshort", (busy_cyc - b0 <= 12) ? 1 : 0, 1);
    chk("t3_busy_end", {31'd0, busy}, 32'h0);

    // 4: framing error then break, no retrigger until line recovers
    d0 = done_cnt;
    send_byte(8'hA5, 1'b0);
    chk("t4_cnt", done_cnt - d0, 1);
    chk("t4_out", {24'd0, dout}, 32'hA5);
    chk("t4_err", {31'd0, err},  32'h1);
    drive_bit(1'b0, 40 * OS);
    chk("t4_break_cnt", done_cnt - d0, 1);
    chk("t4_break_busy", {31'd0, busy}, 32'h0);
    drive_bit(1'b1, OS);
    send_byte(8'h3C, 1'b1);
    drive_bit(1'b1, 4);
    chk("t4_cnt2", done_cnt - d0, 2);
    chk("t4_out2", {24'd0, dout}, 32'h3C);
    chk("t4_err2", {31'd0, err},  32'h0);

    // 5: reset during data bit 3 of 0xF0
    d0 = done_cnt;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, OS);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    #1;
    chk("t5_out_rst",  {24'd0, dout}, 32'h00);
    chk("t5_busy_rst", {31'd0, busy}, 32'h0);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    rst = 1'b0;
    drive_bit(1'b1, OS - 4);
    for (int i = 5; i < 8; i++) drive_bit(1'b1, OS);
    drive_bit(1'b1, 2 * OS);
    chk("t5_cnt", done_cnt - d0, 0);
    chk("t5_out_hold", {24'd0, dout}, 32'h00);
    send_byte(8'h0F, 1'b1);
    drive_bit(1'b1, 4);
    chk("t5_cnt2", done_cnt - d0, 1);
    chk("t5_out2", {24'd0, dout}, 32'h0F);
    chk("t5_err2", {31'd0, err},  32'h0);

    // 6: en low with idle line, then 0x81
    d0 = done_cnt; b0 = busy_cyc;
    en = 1'b0;
    drive_bit(1'b1, 20);
    chk("t6_busy_off", busy_cyc - b0, 0);
    chk("t6_cnt_off",  done_cnt - d0, 0);
    chk("t6_out_off",  {24'd0, dout}, 32'h0F);
    en = 1'b1;
    drive_bit(1'b1, 4);
    send_byte(8'h81, 1'b1);
    drive_bit(1'b1, 8);
    chk("t6_cnt", done_cnt - d0, 1);
    chk("t6_out", {24'd0, dout}, 32'h81);
    chk("t6_err", {31'd0, err},  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
